ball_trail: RTL



---
 rtl/ball_pkg.sv | 14 +
 rtl/trail_ring.sv | 46 ++++
 rtl/ball_trail.sv | 64 ++++++
 3 files changed

// File: rtl/ball_pkg.sv
// ball_pkg: shared ball position type, screen limits and trail square test
package ball_pkg;
  localparam logic [9:0] X_MAX = 10'd639;
  localparam logic [9:0] Y_MAX = 10'd479;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pos_t;
  function automatic logic near(input logic [9:0] a, input logic [9:0] b, input logic [10:0] r);
    logic [10:0] d;
    d = {1'b0, a} - {1'b0, b};
    return (d[10] ? -d : d) <= r;
  endfunction
endpackage

// File: rtl/trail_ring.sv
// trail_ring: ring buffer of the last DEPTH distinct ball positions
module trail_ring
  import ball_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic                clear,
  input  logic                wr_en,
  input  pos_t                wr_data,
  output pos_t [DEPTH-1:0]    ent_o,
  output logic [AW-1:0]       newest_o,
  output logic [AW:0]         count_o
);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL = CW'(DEPTH);
  pos_t [DEPTH-1:0] ent_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] count_q, count_d;
  logic wr;
  assign newest_o = wr_ptr_q - AW'(1);
  assign ent_o = ent_q;
  assign count_o = count_q;
  // write unless cleared or repeating the newest stored position
  always_comb begin
    wr = wr_en && !clear && !(count_q != '0 && wr_data == ent_q[newest_o]);
    wr_ptr_d = clear ? '0 : wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d = clear ? '0 : (wr && count_q != FULL) ? count_q + CW'(1) : count_q;
  end
  // pointer and fill level, async reset
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
    end
  end
  // entry storage needs no reset, stale entries are masked by count
  always_ff @(posedge frame_clk) begin
    if (wr) ent_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/ball_trail.sv
// ball_trail: samples ball position into a trail ring and hit-tests pixels against it
module ball_trail
  import ball_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SAMPLE_DIV = 4,
  parameter int TRAIL_SIZE = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          Reset,
  input  logic          frame_clk,
  input  logic          enable,
  input  logic          clear,
  input  logic [9:0]    BallX,
  input  logic [9:0]    BallY,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  output logic          is_trail,
  output logic [AW-1:0] trail_age,
  output logic [AW:0]   trail_count
);
  localparam int CW = AW + 1;
  localparam logic [3:0] DIV_LAST = 4'(SAMPLE_DIV - 1);
  localparam logic [10:0] R = 11'(TRAIL_SIZE);
  logic [3:0] div_q, div_d;
  logic sample;
  pos_t ball, e;
  pos_t [DEPTH-1:0] ent;
  logic [AW-1:0] newest;
  assign ball = '{x: BallX, y: BallY};
  // frame divider producing one sample event every SAMPLE_DIV enabled frames
  always_comb begin
    sample = enable && div_q == DIV_LAST;
    div_d = clear ? '0 : !enable ? div_q : sample ? '0 : div_q + 4'd1;
  end
  // divider register, async reset
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) div_q <= '0;
    else div_q <= div_d;
  end
  trail_ring #(.DEPTH(DEPTH)) u_ring (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .clear(clear),
    .wr_en(sample),
    .wr_data(ball),
    .ent_o(ent),
    .newest_o(newest),
    .count_o(trail_count)
  );
  // scan from oldest to newest so the youngest hit wins
  always_comb begin
    is_trail = 1'b0;
    trail_age = '0;
    e = '0;
    for (int a = DEPTH - 1; a >= 0; a--) begin
      e = ent[newest - AW'(a)];
      if (CW'(a) < trail_count && near(e.x, DrawX, R) && near(e.y, DrawY, R)) begin
        is_trail = 1'b1;
        trail_age = AW'(a);
      end
    end
  end
endmodule
